// File: rtl/alu_shift_seq.sv
// Multi-cycle shifter/rotator: moves at most STEP bit positions per clock,
// sequenced with a start/busy/done handshake.
module alu_shift_seq #(
  parameter int unsigned N    = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [AW-1:0] amt,
  input  logic [2:0]    op,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  Z
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  state_t        state;
  state_t        next_state;
  logic [N-1:0]  work;
  logic [AW-1:0] count;
  logic [2:0]    mode;
  logic          sign;

  logic          accept;
  logic          last;
  logic [AW-1:0] k;
  logic [N-1:0]  shifted;
  logic [2*N-1:0] rot_l;
  logic [2*N-1:0] rot_r;
  logic          busy_nxt;
  logic          done_nxt;

  // A request is only taken when no operation is in flight.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Final step when the remaining count fits in one clock.
  assign last = ({1'b0, count} <= CW'(STEP));
  assign k    = last ? count : AW'(STEP);

  // One step of the selected mode by k positions.
  always_comb begin
    shifted = work;
    rot_l   = {work, work} << k;
    rot_r   = {work, work} >> k;
    case (mode)
      OP_SLL:  shifted = work << k;
      OP_SRL:  shifted = work >> k;
      OP_SRA:  shifted = (work >> k) | (sign ? ~({N{1'b1}} >> k) : {N{1'b0}});
      OP_ROL:  shifted = rot_l[2*N-1:N];
      OP_ROR:  shifted = rot_r[N-1:0];
      default: shifted = work;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last)  next_state = DONE;
      DONE:    next_state = start ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake flags decoded from the upcoming state.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (next_state)
      SHIFT:   busy_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Datapath: capture on accept, step while shifting, publish on the last step.
  // PASS modes load a zero count so they finish in a single step like amt=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work  <= '0;
      count <= '0;
      mode  <= '0;
      sign  <= 1'b0;
      Z     <= '0;
    end else if (accept) begin
      work  <= A;
      count <= (op > OP_ROR) ? '0 : amt;
      mode  <= op;
      sign  <= A[N-1];
    end else if (state == SHIFT) begin
      work  <= shifted;
      count <= count - k;
      if (last) Z <= shifted;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: directed table, hand-written handshake corners,
// and randomized operations against an arithmetic reference model.
module tb_alu_shift_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [4:0]  amt;
  logic [2:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] Z;

  int total;
  int passed;

  alu_shift_seq #(.N(32), .AW(5), .STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .amt(amt), .op(op),
    .busy(busy), .done(done), .Z(Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [2:0]  o;
    logic [31:0] z;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_z(input logic [31:0] a, input int s, input int o);
    case (o)
      0: return a << s;
      1: return a >> s;
      2: return 32'($signed(a) >>> s);
      3: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4: return (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      default: return a;
    endcase
  endfunction

  function automatic int model_lat(input int s, input int o);
    if (o >= 5 || s == 0) return 1;
    return (s + 3) / 4;
  endfunction

  // Issue one operation and follow it to done (bounded).
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic [2:0] o,
                        output logic [31:0] z, output int lat, output int bcnt, output int zmoved);
    logic [31:0] z_before;
    @(negedge clk);
    A = a; amt = s; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; amt = 5'($urandom); op = 3'($urandom);
    z_before = Z;
    lat = -1; bcnt = 0; zmoved = 0; z = 'x;
    for (int i = 1; i <= 40; i++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (done) begin
        lat = i; z = Z;
        break;
      end
      if (Z !== z_before) zmoved = 1;
    end
  endtask

  vec_t tbl[6];
  logic [31:0] z;
  int lat, bcnt, zm;

  initial begin
    total = 0; passed = 0;
    start = 0; A = 0; amt = 0; op = 0;
    rst = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_z",    Z,         32'd0);
    @(negedge clk); rst = 1'b0;

    tbl[0] = '{32'h000000F1, 5'd4,  3'b000, 32'h00000F10, 1};
    tbl[1] = '{32'h80000000, 5'd31, 3'b010, 32'hFFFFFFFF, 8};
    tbl[2] = '{32'h12345678, 5'd8,  3'b100, 32'h78123456, 2};
    tbl[3] = '{32'h12345678, 5'd8,  3'b011, 32'h34567812, 2};
    tbl[4] = '{32'hDEADBEEF, 5'd0,  3'b001, 32'hDEADBEEF, 1};
    tbl[5] = '{32'hCAFEF00D, 5'd17, 3'b101, 32'hCAFEF00D, 1};

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].s, tbl[i].o, z, lat, bcnt, zm);
      check($sformatf("tbl%0d_z", i),    z,            tbl[i].z);
      check($sformatf("tbl%0d_lat", i),  32'(lat),     32'(tbl[i].lat));
      check($sformatf("tbl%0d_busy", i), 32'(bcnt),    32'(tbl[i].lat));
      check($sformatf("tbl%0d_zhold", i), 32'(zm),     32'd0);
    end

    // done is a single-cycle pulse when no new start follows
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);

    // start pulsed in mid-SHIFT is ignored
    @(negedge clk);
    A = 32'h0000_0003; amt = 5'd20; op = 3'b000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    A = 32'hFFFF_FFFF; amt = 5'd1; op = 3'b001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    check("midstart_lat", 32'(lat), 32'd5);
    check("midstart_z",   Z,        32'h0030_0000);

    // back-to-back: new start held during the DONE cycle
    A = 32'h0000_0001; amt = 5'd12; op = 3'b000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("b2b_done_falls", 32'(done), 32'd0);
    check("b2b_busy",       32'(busy), 32'd1);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    check("b2b_lat", 32'(lat), 32'd3);
    check("b2b_z",   Z,        32'h0000_1000);

    // asynchronous reset on the 3rd cycle of a 31-bit SRA
    @(negedge clk);
    A = 32'h8000_0000; amt = 5'd31; op = 3'b010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_z",    Z,         32'd0);
    @(negedge clk); rst = 1'b0;
    zm = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) zm = 1;
    end
    check("arst_no_done", 32'(zm), 32'd0);
    run_op(32'h1234_5678, 5'd8, 3'b100, z, lat, bcnt, zm);
    check("arst_after_z",   z,        32'h7812_3456);
    check("arst_after_lat", 32'(lat), 32'd2);

    // randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic [2:0]  ro;
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      ro = 3'($urandom_range(0, 7));
      run_op(ra, rs, ro, z, lat, bcnt, zm);
      check($sformatf("rnd%0d_z op=%0d amt=%0d", i, ro, rs), z, model_z(ra, int'(rs), int'(ro)));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_lat(int'(rs), int'(ro))));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
